// File: rtl/ysyx_25020037_issue_sb_if.sv
// Decode/issue/writeback handshake bundle for the issue scoreboard.
// master = IDU/EXU/WBU side, slave = scoreboard.
interface ysyx_25020037_issue_sb_if;
    logic       dec_valid;
    logic       dec_ready;
    logic [3:0] dec_rs1;
    logic [3:0] dec_rs2;
    logic       dec_rs1_en;
    logic       dec_rs2_en;
    logic [3:0] dec_rd;
    logic       dec_rd_we;
    logic       dec_serial;
    logic       exu_ready;
    logic       flush;
    logic       issue_valid;
    logic       wb_valid;
    logic [3:0] wb_rd;
    logic       wb_rd_we;
    logic       wb_serial_done;

    modport master (
        output dec_valid, dec_rs1, dec_rs2,
        output dec_rs1_en, dec_rs2_en,
        output dec_rd, dec_rd_we, dec_serial,
        output exu_ready, flush,
        output wb_valid, wb_rd, wb_rd_we,
        output wb_serial_done,
        input  dec_ready, issue_valid
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2,
        input  dec_rs1_en, dec_rs2_en,
        input  dec_rd, dec_rd_we, dec_serial,
        input  exu_ready, flush,
        input  wb_valid, wb_rd, wb_rd_we,
        input  wb_serial_done,
        output dec_ready, issue_valid
    );
endinterface

// File: rtl/ysyx_25020037_issue_sb.sv
// Issue scoreboard: RAW/WAW interlock and CSR/system serialization.
// Optional stall statistics counter: YSYX_25020037_SB_STAT_EN.
module ysyx_25020037_issue_sb #(
    parameter int NREG         = 16,
    parameter int MAX_INFLIGHT = 3,
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    ysyx_25020037_issue_sb_if.slave sb,
    output logic [CW-1:0]   inflight_cnt,
    output logic [NREG-1:0] busy_mask,
    output logic [1:0]      sb_state,
    output logic            sb_err,
    output logic [31:0]     stall_cycles
);

    localparam logic [CW-1:0] MAXC = CW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } state_t;

    state_t        st, nxt;
    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] inflight;
    logic          err_q;

    logic hazard;
    logic grant;
    logic ready;
    logic fire;
    logic inc_en;
    logic wb_hit;
    logic wb_ok;
    logic wb_under;
    logic done_bad;

    always_comb begin
        hazard = 1'b0;
        if (sb.dec_rs1_en && sb.dec_rs1 != 4'd0
            && cnt[sb.dec_rs1] != '0)
            hazard = 1'b1;
        if (sb.dec_rs2_en && sb.dec_rs2 != 4'd0
            && cnt[sb.dec_rs2] != '0)
            hazard = 1'b1;
        if (sb.dec_rd_we && sb.dec_rd != 4'd0
            && (cnt[sb.dec_rd] == MAXC || inflight == MAXC))
            hazard = 1'b1;
    end

    // Grant first, then derive fire, then the transition that uses it.
    always_comb begin
        grant = 1'b1;
        nxt   = st;
        unique case (st)
            IDLE: begin
                if (sb.dec_valid && sb.dec_serial)
                    grant = (inflight == '0);
            end
            DRAIN:  grant = (inflight == '0);
            SERIAL: grant = 1'b0;
            default: grant = 1'b0;
        endcase

        ready = rst & sb.exu_ready & ~sb.flush
              & ~hazard & grant;
        fire  = sb.dec_valid & ready;

        unique case (st)
            IDLE: begin
                if (sb.dec_valid && sb.dec_serial) begin
                    if (fire)
                        nxt = SERIAL;
                    else if (!sb.flush)
                        nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (sb.flush || !sb.dec_valid)
                    nxt = IDLE;
                else if (fire)
                    nxt = SERIAL;
            end
            SERIAL: begin
                if (sb.wb_serial_done)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        inc_en   = fire & sb.dec_rd_we & (sb.dec_rd != 4'd0);
        wb_hit   = sb.wb_valid & sb.wb_rd_we
                 & (sb.wb_rd != 4'd0);
        wb_ok    = wb_hit & (cnt[sb.wb_rd] != '0);
        wb_under = wb_hit & (cnt[sb.wb_rd] == '0);
        done_bad = sb.wb_serial_done & (st != SERIAL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    // Same-reg issue and retire cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc_en && sb.dec_rd == 4'(i)
                    && !(wb_ok && sb.wb_rd == 4'(i)))
                    cnt[i] <= cnt[i] + 1'b1;
                else if (wb_ok && sb.wb_rd == 4'(i)
                    && !(inc_en && sb.dec_rd == 4'(i)))
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
            err_q    <= 1'b0;
        end else begin
            if (inc_en && !wb_ok)
                inflight <= inflight + 1'b1;
            else if (wb_ok && !inc_en)
                inflight <= inflight - 1'b1;
            if (wb_under || done_bad)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NREG; i++)
            busy_mask[i] = (cnt[i] != '0);
    end

    assign sb.dec_ready   = ready;
    assign sb.issue_valid = fire;
    assign inflight_cnt   = inflight;
    assign sb_state       = st;
    assign sb_err         = err_q;

`ifdef YSYX_25020037_SB_STAT_EN
    logic        stall;
    logic [31:0] stall_q;

    assign stall = sb.dec_valid & ~ready & ~sb.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else if (stall && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ysyx_25020037_issue_sb.sv
// Directed bench for the issue scoreboard with a rule-level
// reference model checked every cycle.
module tb_ysyx_25020037_issue_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  inflight_cnt;
    logic [15:0] busy_mask;
    logic [1:0]  sb_state;
    logic        sb_err;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    ysyx_25020037_issue_sb_if sbif ();

    ysyx_25020037_issue_sb dut (
        .clk          (clk),
        .rst          (rst),
        .sb           (sbif),
        .inflight_cnt (inflight_cnt),
        .busy_mask    (busy_mask),
        .sb_state     (sb_state),
        .sb_err       (sb_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: per-register pending-write counts.
    int          mc [16];
    int          mst;
    bit          merr;
    longint      mstall;

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < 16; i++) s += mc[i];
        return s;
    endfunction

    function automatic bit m_ready();
        bit h;
        if (!rst || !sbif.exu_ready || sbif.flush) return 0;
        h = (sbif.dec_rs1_en && sbif.dec_rs1 != 0
             && mc[sbif.dec_rs1] > 0)
          || (sbif.dec_rs2_en && sbif.dec_rs2 != 0
             && mc[sbif.dec_rs2] > 0)
          || (sbif.dec_rd_we && sbif.dec_rd != 0
             && (mc[sbif.dec_rd] >= 3 || m_total() >= 3));
        if (h) return 0;
        if (mst == 2) return 0;
        if (mst == 1) return m_total() == 0;
        if (sbif.dec_valid && sbif.dec_serial)
            return m_total() == 0;
        return 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mc[i] = 0;
            mst = 0; merr = 0; mstall = 0;
        end else begin
            bit f, dv;
            int nst;
            dv = sbif.dec_valid;
            f  = dv && m_ready();
`ifdef YSYX_25020037_SB_STAT_EN
            if (dv && !m_ready() && !sbif.flush
                && mstall < 64'hFFFF_FFFF)
                mstall++;
`endif
            nst = mst;
            if (mst == 0 && dv && sbif.dec_serial)
                nst = f ? 2 : (sbif.flush ? 0 : 1);
            else if (mst == 1)
                nst = (sbif.flush || !dv) ? 0 : (f ? 2 : 1);
            else if (mst == 2 && sbif.wb_serial_done)
                nst = 0;
            if (sbif.wb_serial_done && mst != 2) merr = 1;
            if (sbif.wb_valid && sbif.wb_rd_we
                && sbif.wb_rd != 0) begin
                if (mc[sbif.wb_rd] > 0) mc[sbif.wb_rd]--;
                else merr = 1;
            end
            if (f && sbif.dec_rd_we && sbif.dec_rd != 0)
                mc[sbif.dec_rd]++;
            mst = nst;
        end
    end

    task automatic chk(string nm, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, got, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [15:0] bm;
        bit r;
        bm = '0;
        for (int i = 0; i < 16; i++) bm[i] = (mc[i] != 0);
        r = m_ready();
        chk("cyc_dec_ready", sbif.dec_ready, r);
        chk("cyc_issue_valid", sbif.issue_valid,
            r && sbif.dec_valid);
        chk("cyc_inflight", inflight_cnt, m_total());
        chk("cyc_busy_mask", busy_mask, bm);
        chk("cyc_state", sb_state, mst);
        chk("cyc_err", sb_err, merr);
        chk("cyc_stall", stall_cycles, mstall);
    end

    task automatic idle_in();
        sbif.dec_valid = 0; sbif.dec_serial = 0;
        sbif.dec_rs1 = 0; sbif.dec_rs2 = 0;
        sbif.dec_rs1_en = 0; sbif.dec_rs2_en = 0;
        sbif.dec_rd = 0; sbif.dec_rd_we = 0;
        sbif.exu_ready = 1; sbif.flush = 0;
        sbif.wb_valid = 0; sbif.wb_rd = 0;
        sbif.wb_rd_we = 0; sbif.wb_serial_done = 0;
    endtask

    task automatic dec(input logic [3:0] rd,
                       input logic we,
                       input logic [3:0] rs1,
                       input logic ser);
        sbif.dec_valid = 1; sbif.dec_rd = rd;
        sbif.dec_rd_we = we; sbif.dec_rs1 = rs1;
        sbif.dec_rs1_en = 1; sbif.dec_serial = ser;
    endtask

    task automatic wb(input logic [3:0] rd);
        sbif.wb_valid = 1; sbif.wb_rd = rd; sbif.wb_rd_we = 1;
    endtask

    task automatic nowb();
        sbif.wb_valid = 0; sbif.wb_rd_we = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 0;
        idle_in();
        dec(4'd1, 1, 4'd0, 0);
        tick(); tick();
        chk("rst_dec_ready", sbif.dec_ready, 0);
        chk("rst_issue_valid", sbif.issue_valid, 0);
        chk("rst_inflight", inflight_cnt, 0);
        chk("rst_state", sb_state, 0);
        idle_in();
        rst = 1;
        tick();

        // RAW on x5, released the cycle after its retire
        dec(4'd5, 1, 4'd0, 0);
        #1 chk("add_x5_ready", sbif.dec_ready, 1);
        tick();
        dec(4'd6, 1, 4'd5, 0);
        #1 chk("raw_stall", sbif.dec_ready, 0);
        chk("busy5_set", busy_mask[5], 1);
        tick();
        wb(4'd5);
        #1 chk("no_bypass", sbif.dec_ready, 0);
        tick();
        nowb();
        #1 chk("raw_release", sbif.dec_ready, 1);
        chk("busy5_clr", busy_mask[5], 0);
        tick();
        idle_in(); wb(4'd6);
        tick();
        nowb();

        // Total in-flight limit
        for (int i = 0; i < 3; i++) begin
            dec(4'd3, 1, 4'd0, 0);
            tick();
        end
        dec(4'd4, 1, 4'd0, 0);
        #1 chk("inflight_3", inflight_cnt, 3);
        chk("full_stall", sbif.dec_ready, 0);
        tick();
        wb(4'd3);
        #1 chk("full_wb_cycle", sbif.dec_ready, 0);
        tick();
        nowb();
        #1 chk("full_release", sbif.dec_ready, 1);
        tick();
        idle_in(); wb(4'd3); tick();
        wb(4'd3); tick();
        wb(4'd4); tick();
        nowb();

        // x0 is never tracked
        dec(4'd0, 1, 4'd0, 0);
        tick();
        dec(4'd1, 0, 4'd0, 0);
        #1 chk("x0_ready", sbif.dec_ready, 1);
        chk("x0_inflight", inflight_cnt, 0);
        tick();

        // Serial drain -> issue -> serial wait
        dec(4'd1, 1, 4'd0, 0); tick();
        dec(4'd2, 1, 4'd0, 0); tick();
        dec(4'd10, 1, 4'd0, 1);
        #1 chk("ser_blocked", sbif.dec_ready, 0);
        tick();
        chk("ser_drain", sb_state, 1);
        wb(4'd1); tick();
        wb(4'd2);
        #1 chk("drain_wait", sbif.dec_ready, 0);
        tick();
        nowb();
        #1 chk("drain_ready", sbif.dec_ready, 1);
        tick();
        chk("ser_serial", sb_state, 2);
        chk("ser_busy10", busy_mask[10], 1);
        dec(4'd11, 1, 4'd0, 0);
        #1 chk("serial_block", sbif.dec_ready, 0);
        wb(4'd10); sbif.wb_serial_done = 1;
        tick();
        nowb(); sbif.wb_serial_done = 0;
        #1 chk("ser_idle", sb_state, 0);
        chk("post_ser_ready", sbif.dec_ready, 1);
        tick();
        idle_in(); wb(4'd11); tick();
        nowb();

        // Same-cycle issue/retire on x7; underflow on x9
        dec(4'd7, 1, 4'd0, 0); tick();
        dec(4'd7, 1, 4'd0, 0); wb(4'd7); tick();
        idle_in();
        #1 chk("x7_kept", busy_mask[7], 1);
        chk("x7_inflight", inflight_cnt, 1);
        wb(4'd9); tick();
        nowb();
        #1 chk("under_err", sb_err, 1);
        chk("under_inflight", inflight_cnt, 1);
        wb(4'd7); tick();
        nowb();

        // Flush kills issue; flush does not leave SERIAL
        dec(4'd8, 1, 4'd0, 0); sbif.flush = 1;
        #1 chk("flush_issue", sbif.issue_valid, 0);
        tick();
        chk("flush_cnt", inflight_cnt, 0);
        sbif.flush = 0;
        dec(4'd0, 0, 4'd0, 1);
        tick();
        dec(4'd8, 1, 4'd0, 0); sbif.flush = 1;
        tick();
        chk("flush_in_serial", sb_state, 2);

        // Async reset mid-SERIAL
        #2 rst = 0;
        #1 chk("arst_state", sb_state, 0);
        chk("arst_err", sb_err, 0);
        chk("arst_ready", sbif.dec_ready, 0);
        chk("arst_issue", sbif.issue_valid, 0);
        idle_in();
        tick();
        rst = 1;
        tick();

        // Serial-done outside SERIAL is a protocol error
        sbif.wb_serial_done = 1;
        tick();
        sbif.wb_serial_done = 0;
        #1 chk("stray_done_err", sb_err, 1);
        chk("stray_done_state", sb_state, 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
